// File: rtl/occ_pkg.sv
// Shared types and constants for the multi-gate parking occupancy counter.
package occ_pkg;

  // Per-gate pass tracker states: entry path EN*, exit path EX*.
  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3
  } gate_state_t;

  // Sensor pair codes, packed as {outer, inner}; 1 = beam blocked.
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_OUT  = 2'b10;
  localparam logic [1:0] S_IN   = 2'b01;
  localparam logic [1:0] S_BOTH = 2'b11;

  // Width needed to hold an occupancy value in 0..capacity.
  function automatic int cnt_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/multi_gate_occupancy_gate_detector.sv
// gate_detector: synchronizes one gate's outer/inner photosensors and tracks
// a car's pass through the gate, emitting one-cycle entry/exit/error pulses.
module gate_detector
  import occ_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic outer_sw,
  input  logic inner_sw,
  output logic outer_led,
  output logic inner_led,
  output logic enter_pulse,
  output logic exit_pulse,
  output logic seq_err
);

  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  gate_state_t state_q, state_d;
  logic        enter_q, enter_d;
  logic        exit_q, exit_d;
  logic        err_q, err_d;

  // Two-flop synchronizer feed for the raw {outer, inner} sensor pair.
  always_comb begin
    sync1_d = {outer_sw, inner_sw};
    sync2_d = sync1_q;
  end

  // Synchronizer, FSM state and registered event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= S_NONE;
      sync2_q <= S_NONE;
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
    end
  end

  // Pass tracker: hold on same code, advance on next code, step back on the
  // previous code (car reverses), drop to IDLE on 00 (aborted pass); anything
  // else is an impossible sensor sequence and raises seq_err.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        case (sync2_q)
          S_NONE:  state_d = IDLE;
          S_OUT:   state_d = EN1;
          S_IN:    state_d = EX1;
          default: begin state_d = IDLE; err_d = 1'b1; end
        endcase
      end
      EN1: begin
        case (sync2_q)
          S_OUT:   state_d = EN1;
          S_BOTH:  state_d = EN2;
          S_NONE:  state_d = IDLE;
          default: begin state_d = IDLE; err_d = 1'b1; end
        endcase
      end
      EN2: begin
        case (sync2_q)
          S_BOTH:  state_d = EN2;
          S_IN:    state_d = EN3;
          S_OUT:   state_d = EN1;
          default: state_d = IDLE;
        endcase
      end
      EN3: begin
        case (sync2_q)
          S_IN:    state_d = EN3;
          S_NONE:  begin state_d = IDLE; enter_d = 1'b1; end
          S_BOTH:  state_d = EN2;
          default: begin state_d = IDLE; err_d = 1'b1; end
        endcase
      end
      EX1: begin
        case (sync2_q)
          S_IN:    state_d = EX1;
          S_BOTH:  state_d = EX2;
          S_NONE:  state_d = IDLE;
          default: begin state_d = IDLE; err_d = 1'b1; end
        endcase
      end
      EX2: begin
        case (sync2_q)
          S_BOTH:  state_d = EX2;
          S_OUT:   state_d = EX3;
          S_IN:    state_d = EX1;
          default: state_d = IDLE;
        endcase
      end
      EX3: begin
        case (sync2_q)
          S_OUT:   state_d = EX3;
          S_NONE:  begin state_d = IDLE; exit_d = 1'b1; end
          S_BOTH:  state_d = EX2;
          default: begin state_d = IDLE; err_d = 1'b1; end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign outer_led   = sync2_q[1];
  assign inner_led   = sync2_q[0];
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign seq_err     = err_q;

endmodule

// File: rtl/multi_gate_occupancy.sv
// multi_gate_occupancy: parking-lot occupancy counter fed by NUM_GATES
// two-sensor gates. Entries and exits from all gates are netted each cycle
// and the count is clamped to [0, CAPACITY] with sticky ovf/unf flags.
// Optional feature macro OCC_PEAK_EN adds a peak-occupancy output.
module multi_gate_occupancy
  import occ_pkg::*;
#(
  parameter  int NUM_GATES = 2,
  parameter  int CAPACITY  = 16,
  localparam int CNT_W     = cnt_width(CAPACITY)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer_sw,
  input  logic [NUM_GATES-1:0] inner_sw,
  output logic [NUM_GATES-1:0] outer_led,
  output logic [NUM_GATES-1:0] inner_led,
  output logic [NUM_GATES-1:0] enter_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [NUM_GATES-1:0] seq_err,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 unf
`ifdef OCC_PEAK_EN
  ,
  output logic [CNT_W-1:0]     peak
`endif
);

  // Four guard bits cover a net swing of up to +/-8 gates with sign.
  localparam int                       SUM_W = CNT_W + 4;
  localparam logic signed [SUM_W-1:0]  CAP_S = SUM_W'(CAPACITY);
  localparam logic [CNT_W-1:0]         CAP_C = CNT_W'(CAPACITY);

  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic signed [SUM_W-1:0] net;
  logic signed [SUM_W-1:0] total;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_detector u_det (
      .clk         (clk),
      .reset       (reset),
      .outer_sw    (outer_sw[g]),
      .inner_sw    (inner_sw[g]),
      .outer_led   (outer_led[g]),
      .inner_led   (inner_led[g]),
      .enter_pulse (enter_pulse[g]),
      .exit_pulse  (exit_pulse[g]),
      .seq_err     (seq_err[g])
    );
  end

  function automatic logic below_zero(input logic signed [SUM_W-1:0] s);
    return s[SUM_W-1];
  endfunction

  function automatic logic above_cap(input logic signed [SUM_W-1:0] s);
    return !s[SUM_W-1] && (s > CAP_S);
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] s);
    if (below_zero(s)) begin
      return '0;
    end else if (above_cap(s)) begin
      return CAP_C;
    end
    return s[CNT_W-1:0];
  endfunction

  // Net this cycle's entries against exits, then clamp and flag the excess.
  always_comb begin
    net = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      net = net + $signed({{(SUM_W-1){1'b0}}, enter_pulse[g]})
                - $signed({{(SUM_W-1){1'b0}}, exit_pulse[g]});
    end
    total   = $signed({4'b0000, count_q}) + net;
    count_d = sat_count(total);
    ovf_d   = ovf_q | above_cap(total);
    unf_d   = unf_q | below_zero(total);
  end

  // Occupancy count and sticky overflow/underflow flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CAP_C);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

`ifdef OCC_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // Track the highest occupancy seen since reset.
  always_comb begin
    peak_d = (count_q > peak_q) ? count_q : peak_q;
  end

  // Peak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: doc/multi_gate_occupancy.md
MULTI_GATE_OCCUPANCY -- requirements
Module: multi_gate_occupancy

Interface
REQ-001 SHALL have parameter NUM_GATES, default 2, meaning number of gates, each with one outer and one inner photosensor (range 1..8).
REQ-002 SHALL have parameter CAPACITY, default 16, meaning maximum lot occupancy (range 1..255).
REQ-003 SHALL have derived localparam CNT_W = $clog2(CAPACITY+1), meaning the count width.
REQ-004 SHALL have these ports:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- outer_sw  input  NUM_GATES  outer sensor per gate; 1 = blocked; asynchronous to clk.
- inner_sw  input  NUM_GATES  inner sensor per gate; 1 = blocked; asynchronous to clk.
- outer_led  output  NUM_GATES  synchronized outer sensor value.
- inner_led  output  NUM_GATES  synchronized inner sensor value.
- enter_pulse  output  NUM_GATES  one-cycle pulse per completed entry.
- exit_pulse  output  NUM_GATES  one-cycle pulse per completed exit.
- seq_err  output  NUM_GATES  one-cycle pulse on an illegal sensor transition.
- count  output  CNT_W  current occupancy.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- ovf  output  1  sticky; an entry was dropped at capacity.
- unf  output  1  sticky; an exit was dropped at zero.

Function
REQ-005 SHALL pass each sensor through a 2-flop synchronizer; outer_led/inner_led SHALL be the second-stage outputs.
REQ-006 SHALL run an independent per-gate FSM on the synchronized pair {outer,inner}, with states IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
REQ-007 Entry path SHALL be IDLE-(10)->EN1-(11)->EN2-(01)->EN3-(00)->IDLE, asserting enter_pulse on that final transition.
REQ-008 Exit path SHALL be IDLE-(01)->EX1-(11)->EX2-(10)->EX3-(00)->IDLE, asserting exit_pulse on that final transition.
REQ-009 Any state SHALL hold when the input is unchanged, and SHALL step back one state when the input equals the previous state's code (car reverses).
REQ-010 Input 00 from EN1/EN2/EX1/EX2 SHALL return the FSM to IDLE with no event and no error (aborted pass).
REQ-011 Any other transition (e.g. EN1 seeing 01, IDLE seeing 11) SHALL move the FSM to IDLE and pulse seq_err for one cycle.
REQ-012 enter_pulse/exit_pulse/seq_err SHALL be registered FSM outputs, asserted on the 3rd rising edge after the edge where the raw inputs first meet setup at the final code.
REQ-013 count SHALL update on the rising edge following the pulse (1-cycle latency from pulse to count).
REQ-014 Per cycle, net = popcount(enter_pulse) - popcount(exit_pulse), computed at signed CNT_W+4 width.
REQ-015 count_next SHALL be count+net clamped to [0, CAPACITY].
REQ-016 ovf SHALL set when count+net > CAPACITY, and unf SHALL set when count+net < 0; both are cleared only by reset.
REQ-017 Simultaneous entries and exits at different gates SHALL be netted before clamping, so an entry and an exit in the same cycle at full leaves count unchanged with no ovf.
REQ-018 full and empty SHALL be combinational decodes of count.

Reset
REQ-019 Asserting reset (low) SHALL immediately clear synchronizers, FSMs (IDLE), pulses, count, ovf, unf, and the peak register (if present); empty=1, full=0.
REQ-020 Reset mid-sequence SHALL discard the partial pass; after release, the FSM SHALL restart from IDLE on current inputs (a blocked input then follows REQ-007/008/011 rules).

Configuration
REQ-021 With macro OCC_PEAK_EN defined, the module SHALL add output peak [CNT_W], holding the maximum count since reset and updating the cycle after count exceeds it.
REQ-022 Without OCC_PEAK_EN, the peak port and register SHALL be absent.

Structure
REQ-023 Package occ_pkg SHALL hold the gate_state_t enum, the 2-bit sensor code constants (S_NONE, S_OUT, S_IN, S_BOTH), and a cnt_width function.
REQ-024 The per-gate synchronizer plus FSM SHALL be the sub-module gate_detector, instantiated NUM_GATES times in a generate loop.

Verification
REQ-025 Gate 0 driven 00,10,11,01,00 (each held 4 cycles) -> one enter_pulse[0]; count 0->1; empty drops.
REQ-026 Gate 1 driven 01,11,10,00 at count=3 -> one exit_pulse[1]; count=2; no seq_err.
REQ-027 Gate 0 driven 10,11,10,00 (reversal then abort) -> no pulses, no seq_err, count unchanged.
REQ-028 Gate 0 driven 10 then 01 directly -> seq_err[0] pulse; FSM IDLE; count unchanged.
REQ-029 CAPACITY=4 at count=4: an extra entry gives count=4 and ovf=1; an entry on gate 0 with a same-cycle exit on gate 1 gives count=4 and ovf unchanged.
REQ-030 Reset asserted while gate 0 is in EN2 at count=2 -> count=0, empty=1, ovf=unf=0; completing the remaining sensor codes gives no enter_pulse.
